// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned restoring divider feeding the HI/LO write port.
// Remainder goes to hi_o, quotient to lo_o, delivered as a one-cycle we pulse.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic        busy,
  output logic        we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, BUSY, FINISH} state_t;

  state_t      state, state_nx;
  logic        accept;
  logic [4:0]  cnt;
  logic [63:0] rq;
  logic [31:0] dsr;
  logic        q_neg, r_neg, dz;
  logic [31:0] a_abs, b_abs;
  logic        ge;
  logic [31:0] sub;
  logic [31:0] quo_fix, rem_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !annul) begin
          accept   = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (annul)              state_nx = IDLE;
        else if (cnt == 5'd31)  state_nx = FINISH;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign a_abs = (signed_op && dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign b_abs = (signed_op && divisor[31])  ? (~divisor + 32'd1)  : divisor;

  // The shifted partial remainder is 33 bits (rq[63:31]); it is always below
  // 2*divisor, so the 32-bit difference is exact whenever the trial succeeds.
  assign ge  = rq[63:31] >= {1'b0, dsr};
  assign sub = rq[62:31] - dsr;

  // Divide by zero leaves the dividend in the remainder naturally; only the
  // quotient needs forcing so the sign fix-up cannot turn it into 1.
  assign quo_fix = dz ? 32'hFFFF_FFFF : (q_neg ? (~rq[31:0] + 32'd1) : rq[31:0]);
  assign rem_fix = r_neg ? (~rq[63:32] + 32'd1) : rq[63:32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      we    <= 1'b0;
      hi_o  <= '0;
      lo_o  <= '0;
      cnt   <= '0;
      rq    <= '0;
      dsr   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz    <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            rq    <= {32'd0, a_abs};
            dsr   <= b_abs;
            q_neg <= signed_op & (dividend[31] ^ divisor[31]);
            r_neg <= signed_op & dividend[31];
            dz    <= (divisor == 32'd0);
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (annul) begin
            busy <= 1'b0;
          end else begin
            rq  <= ge ? {sub, rq[30:0], 1'b1} : {rq[62:0], 1'b0};
            cnt <= cnt + 5'd1;
          end
        end
        FINISH: begin
          busy <= 1'b0;
          if (!annul) begin
            we   <= 1'b1;
            hi_o <= rem_fix;
            lo_o <= quo_fix;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: hand-computed quotients/remainders,
// latency, cancel, back-to-back and asynchronous reset behaviour.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        busy;
  logic        we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = 0;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .annul     (annul),
    .busy      (busy),
    .we        (we),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; signed_op = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; signed_op = ~s; dividend = 32'hA5A5_5A5A; divisor = 32'h0000_0003;
  endtask

  // Steps from just after E0 until we is seen; poke > 0 injects a start pulse
  // before edge E<poke>, which must be ignored because the unit is busy.
  task automatic wait_we(input int poke, output int n, output int bn);
    n = -1;
    bn = busy ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == poke) begin
        @(negedge clk);
        start = 1'b1; dividend = 32'h0000_0007; divisor = 32'h0000_0001;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (busy) bn++;
      if (busy && we) chk("busy_and_we", 32'd1, 32'd0);
      if (we) begin
        n = i;
        last_we_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int poke);
    int n, bn;
    start_op(s, a, b);
    chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
    wait_we(poke, n, bn);
    chk({tag, "_latency"}, n, 32'd33);
    chk({tag, "_busy_cycles"}, bn, 32'd33);
    chk({tag, "_lo"}, lo_o, exp_lo);
    chk({tag, "_hi"}, hi_o, exp_hi);
  endtask

  task automatic no_we(input string tag, input int ncyc);
    int seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (we) seen++;
    end
    chk(tag, seen, 32'd0);
  endtask

  initial begin
    int first_we, gap;
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0; annul = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_hi", hi_o, 32'd0);
    chk("rst_lo", lo_o, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
    @(posedge clk); #1;
    chk("we_one_cycle", 32'(we), 32'd0);
    chk("hold_lo", lo_o, 32'd14);
    chk("hold_hi", hi_o, 32'd2);

    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    run_div("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 0);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 0);
    run_div("s_dz", 1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 0);
    run_div("u_dz", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 0);
    run_div("s_dz_neg", 1'b1, 32'h8000_0005, 32'd0, 32'hFFFF_FFFF, 32'h8000_0005, 0);
    run_div("ignored_start", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 5);

    // Cancel at step 10; a stray start at step 5 is ignored as well.
    start_op(1'b0, 32'd20, 32'd4);
    repeat (4) @(posedge clk);
    @(negedge clk); start = 1'b1; dividend = 32'd9; divisor = 32'd2;
    @(posedge clk); #1; start = 1'b0;
    chk("annul_busy_before", 32'(busy), 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1; annul = 1'b0;
    chk("annul_busy", 32'(busy), 32'd0);
    chk("annul_we", 32'(we), 32'd0);
    chk("annul_lo_kept", lo_o, 32'd333);
    chk("annul_hi_kept", hi_o, 32'd1);
    no_we("annul_no_we", 40);

    // annul and start together in IDLE: start is dropped.
    @(negedge clk); start = 1'b1; annul = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk); #1; start = 1'b0; annul = 1'b0;
    chk("annul_start_busy", 32'(busy), 32'd0);
    no_we("annul_start_no_we", 40);

    run_div("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 0);

    run_div("b2b_first", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);
    first_we = last_we_cyc;
    run_div("b2b_second", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 0);
    gap = last_we_cyc - first_we;
    chk("b2b_gap", gap, 32'd34);

    // Asynchronous reset between edges, mid-operation.
    start_op(1'b0, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_we", 32'(we), 32'd0);
    chk("arst_hi", hi_o, 32'd0);
    chk("arst_lo", lo_o, 32'd0);
    rst = 1'b0;
    no_we("arst_no_we", 40);

    run_div("u7_9", 1'b0, 32'd7, 32'd9, 32'd0, 32'd7, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
